// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//
// Contents:
//   FETCH_XLEN         datapath / PC width used by the fetch entry struct
//   FETCH_IMEM_ADDR_W  instruction-memory word-index width (256 words)
//   FETCH_RESET_PC     PC loaded on reset (word-aligned)
//   fetch_state_e      RUN / HALT sequencer state
//   fetch_entry_t      one buffered instruction word tagged with its byte PC
package fetch_pkg;

    localparam int FETCH_XLEN        = 32;
    localparam int FETCH_IMEM_ADDR_W = 8;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch sequencer and its environment.
//
// Signals:
//   imem_addr      word index presented to the instruction memory
//   imem_rdata     registered memory read data (valid one cycle after address)
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    byte target PC of the redirect
//   out_valid      instruction available to decode
//   out_ready      decode accepts the current instruction
//   out_instr      instruction word
//   out_pc         byte PC of out_instr
//
// Modports:
//   master  the fetch sequencer side
//   slave   memory / branch unit / decode side
interface fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched words tagged with their PC.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   push       write push_data this cycle
//   push_data  entry to write
//   pop        consume the head entry this cycle
//   flush      synchronous clear; discards contents and any same-cycle push
//   count      number of valid entries (0..2)
//   head       oldest entry, all zeros when empty
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry_reg [2];
    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;

    logic do_pop;
    logic do_push;

    // Guards keep the pointers consistent even if a caller misbehaves;
    // the fetch controller never pushes into a full FIFO without a pop.
    always_comb begin
        do_pop  = pop && (count_reg != 2'd0);
        do_push = push && ((count_reg != 2'd2) || do_pop);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg[gi] <= '0;
                end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            // A same-cycle pop has already been seen by decode; dropping
            // everything here is equivalent to "pop, then clear".
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_comb begin
        count = count_reg;
        head  = '0;
        if (count_reg != 2'd0) begin
            head = entry_reg[rd_ptr_reg];
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous-read instruction memory.
//
// Owns the PC, presents one word address per cycle, tags each returning
// word with the PC it was fetched from and buffers it in a 2-entry skid
// FIFO so decode can stall. Redirects flush buffered and in-flight words;
// a misaligned redirect target halts fetch and raises a sticky fault.
//
// Ports:
//   clk     clock
//   reset   asynchronous active-high reset
//   enable  permit new fetches (buffered / in-flight words still drain)
//   bus     fetch_if master: imem_addr/imem_rdata, redirect_valid/redirect_pc,
//           out_valid/out_ready/out_instr/out_pc
//   fault   sticky misaligned-redirect flag, cleared only by reset
//
// XLEN must match fetch_pkg::FETCH_XLEN and the width of the bus interface.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN        = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = FETCH_RESET_PC,
    parameter int              IMEM_ADDR_W = FETCH_IMEM_ADDR_W
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enable,
    fetch_if.master  bus,
    output logic     fault
);

    fetch_state_e    state_reg,    state_next;
    logic [XLEN-1:0] pc_reg,       pc_next;
    logic            inflight_reg, inflight_next;
    logic [XLEN-1:0] req_pc_reg,   req_pc_next;
    logic            fault_reg,    fault_next;

    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_push_data;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;

    logic         pop;
    logic         take_redirect;
    logic         misaligned;
    logic         issue;
    logic [2:0]   occupancy;

    // The memory samples imem_addr on every edge; only the issue flag
    // decides whether that read is tracked as a real fetch.
    assign bus.imem_addr = {{(XLEN-IMEM_ADDR_W){1'b0}}, pc_reg[IMEM_ADDR_W+1:2]};

    always_comb begin
        bus.out_valid = (state_reg == RUN) && (fifo_count != 2'd0);
        bus.out_instr = fifo_head.instr;
        bus.out_pc    = fifo_head.pc;
    end

    assign fault = fault_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        inflight_next = 1'b0;
        req_pc_next   = req_pc_reg;
        fault_next    = fault_reg;

        pop           = bus.out_valid && bus.out_ready;
        take_redirect = (state_reg == RUN) && bus.redirect_valid;
        misaligned    = (bus.redirect_pc[1:0] != 2'b00);

        // Slots committed after this cycle: buffered + returning - leaving.
        // Issuing only while this is below 2 keeps count + inflight <= 2.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
        issue     = (state_reg == RUN) && enable && !bus.redirect_valid
                    && (occupancy < 3'd2);

        fifo_push              = inflight_reg;
        fifo_push_data.pc      = req_pc_reg;
        fifo_push_data.instr   = bus.imem_rdata;
        fifo_pop               = pop;
        fifo_flush             = take_redirect;

        if (issue) begin
            inflight_next = 1'b1;
            req_pc_next   = pc_reg;
            pc_next       = pc_reg + XLEN'(4);
        end

        // Redirect drops the word returning this cycle (flush wins over the
        // push) and leaves inflight clear so nothing stale arrives later.
        if (take_redirect) begin
            inflight_next = 1'b0;
            if (misaligned) begin
                state_next = HALT;
                fault_next = 1'b1;
            end else begin
                pc_next = bus.redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
            req_pc_reg   <= '0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= inflight_next;
            req_pc_reg   <= req_pc_next;
            fault_reg    <= fault_next;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule
